biriscv_exec_pipe: RTL and testbench

BIRISCV_EXEC_PIPE -- requirements
Module: biriscv_exec_pipe

---
 rtl/biriscv_exec_pipe.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_biriscv_exec_pipe.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_exec_pipe.sv
// biriscv_exec_pipe: RV32I integer execute unit with a configurable-depth
// result pipeline, registered branch resolution and a same-cycle redirect.
// Optional build macro EXEC_SERIAL_SHIFT_EN: when defined, shifts with a
// non-zero amount run one bit per cycle through an IDLE/SHIFT state machine
// (stall_o high while shifting); otherwise a single-cycle barrel shifter is used.
module biriscv_exec_pipe #(
    parameter int RESULT_STAGES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    input  logic        ext_complete_i,
    input  logic [31:0] ext_result_i,
    output logic        stall_o,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o,
    output logic        branch_request_o,
    output logic        branch_is_taken_o,
    output logic        branch_is_not_taken_o,
    output logic [31:0] branch_source_o,
    output logic [31:0] branch_pc_o,
    output logic        branch_is_call_o,
    output logic        branch_is_ret_o,
    output logic        branch_is_jmp_o,
    output logic        branch_d_request_o,
    output logic [31:0] branch_d_pc_o
);
    localparam int         LAST     = RESULT_STAGES - 1;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    // Shift helper shared by the barrel path and the one-bit serial step
    function automatic logic [31:0] shift_fn(input logic [31:0] val, input logic [4:0] amt,
                                             input logic right, input logic arith);
        logic [31:0] res;
        if (!right) begin
            res = val << amt;
        end else if (arith) begin
            res = $unsigned($signed(val) >>> amt);
        end else begin
            res = val >> amt;
        end
        return res;
    endfunction

    logic [6:0]  op_s;
    logic [2:0]  f3_s;
    logic [31:0] a_s, b_s, alu_b_s;
    logic [31:0] imm_i_s, imm_b_s, imm_j_s, imm_u_s;
    logic        stall_s, accept_s;

    assign op_s     = opcode_opcode_i[6:0];
    assign f3_s     = opcode_opcode_i[14:12];
    assign a_s      = opcode_ra_operand_i;
    assign b_s      = opcode_rb_operand_i;
    assign imm_i_s  = {{20{opcode_opcode_i[31]}}, opcode_opcode_i[31:20]};
    assign imm_b_s  = {{19{opcode_opcode_i[31]}}, opcode_opcode_i[31], opcode_opcode_i[7],
                       opcode_opcode_i[30:25], opcode_opcode_i[11:8], 1'b0};
    assign imm_j_s  = {{11{opcode_opcode_i[31]}}, opcode_opcode_i[31], opcode_opcode_i[19:12],
                       opcode_opcode_i[20], opcode_opcode_i[30:21], 1'b0};
    assign imm_u_s  = {opcode_opcode_i[31:12], 12'd0};
    assign alu_b_s  = (op_s == OP_IMM) ? imm_i_s : b_s;
    assign accept_s = opcode_valid_i & ~hold_i & ~stall_s;

    logic [31:0] result_s;

    // ALU result for the presented instruction (unknown opcodes give zero)
    always_comb begin
        result_s = 32'd0;
        case (op_s)
            OP_R, OP_IMM: begin
                case (f3_s)
                    3'b000:  result_s = ((op_s == OP_R) && opcode_opcode_i[30]) ? (a_s - alu_b_s) : (a_s + alu_b_s);
                    3'b001:  result_s = shift_fn(a_s, alu_b_s[4:0], 1'b0, 1'b0);
                    3'b010:  result_s = {31'd0, ($signed(a_s) < $signed(alu_b_s))};
                    3'b011:  result_s = {31'd0, (a_s < alu_b_s)};
                    3'b100:  result_s = a_s ^ alu_b_s;
                    3'b101:  result_s = shift_fn(a_s, alu_b_s[4:0], 1'b1, opcode_opcode_i[30]);
                    3'b110:  result_s = a_s | alu_b_s;
                    3'b111:  result_s = a_s & alu_b_s;
                    default: result_s = 32'd0;
                endcase
            end
            OP_LUI:          result_s = imm_u_s;
            OP_AUIPC:        result_s = opcode_pc_i + imm_u_s;
            OP_JAL, OP_JALR: result_s = opcode_pc_i + 32'd4;
            default:         result_s = 32'd0;
        endcase
    end

    logic        br_is_branch_s, br_taken_s, br_call_s, br_ret_s, br_jump_s, br_jmp_s;
    logic [31:0] br_target_s;

    // Branch/jump decode: condition, target and call/return classification
    always_comb begin
        br_is_branch_s = 1'b0;
        br_taken_s     = 1'b0;
        br_call_s      = 1'b0;
        br_ret_s       = 1'b0;
        br_jump_s      = 1'b0;
        br_target_s    = opcode_pc_i + imm_b_s;
        case (op_s)
            OP_BR: begin
                br_is_branch_s = 1'b1;
                case (f3_s)
                    3'b000:  br_taken_s = (a_s == b_s);
                    3'b001:  br_taken_s = (a_s != b_s);
                    3'b100:  br_taken_s = ($signed(a_s) <  $signed(b_s));
                    3'b101:  br_taken_s = ($signed(a_s) >= $signed(b_s));
                    3'b110:  br_taken_s = (a_s <  b_s);
                    3'b111:  br_taken_s = (a_s >= b_s);
                    default: br_is_branch_s = 1'b0;
                endcase
            end
            OP_JAL: begin
                br_is_branch_s = 1'b1;
                br_taken_s     = 1'b1;
                br_jump_s      = 1'b1;
                br_target_s    = opcode_pc_i + imm_j_s;
                br_call_s      = (opcode_rd_idx_i == 5'd1);
            end
            OP_JALR: begin
                br_is_branch_s = 1'b1;
                br_taken_s     = 1'b1;
                br_jump_s      = 1'b1;
                br_target_s    = (a_s + imm_i_s) & 32'hFFFF_FFFE;
                br_ret_s       = (opcode_ra_idx_i == 5'd1) && (imm_i_s == 32'd0);
                br_call_s      = (opcode_rd_idx_i == 5'd1) && !br_ret_s;
            end
            default: br_is_branch_s = 1'b0;
        endcase
        br_jmp_s = br_jump_s & ~br_call_s & ~br_ret_s;
    end

    assign branch_d_request_o = accept_s & br_taken_s;
    assign branch_d_pc_o      = br_target_s;

    // Registered branch outcome: one pulse per accepted branch, frozen by hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_request_o      <= 1'b0;
            branch_is_taken_o     <= 1'b0;
            branch_is_not_taken_o <= 1'b0;
            branch_is_call_o      <= 1'b0;
            branch_is_ret_o       <= 1'b0;
            branch_is_jmp_o       <= 1'b0;
            branch_source_o       <= 32'd0;
            branch_pc_o           <= 32'd0;
        end else if (!hold_i) begin
            if (accept_s && br_is_branch_s) begin
                branch_request_o      <= 1'b1;
                branch_is_taken_o     <= br_taken_s;
                branch_is_not_taken_o <= ~br_taken_s;
                branch_is_call_o      <= br_call_s;
                branch_is_ret_o       <= br_ret_s;
                branch_is_jmp_o       <= br_jmp_s;
                branch_source_o       <= opcode_pc_i;
                branch_pc_o           <= br_taken_s ? br_target_s : (opcode_pc_i + 32'd4);
            end else begin
                branch_request_o      <= 1'b0;
                branch_is_taken_o     <= 1'b0;
                branch_is_not_taken_o <= 1'b0;
                branch_is_call_o      <= 1'b0;
                branch_is_ret_o       <= 1'b0;
                branch_is_jmp_o       <= 1'b0;
            end
        end
    end

    logic        s0_valid_s;
    logic [4:0]  s0_rd_s;
    logic [31:0] s0_val_s;

`ifdef EXEC_SERIAL_SHIFT_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} shift_state_t;
    shift_state_t state_r, state_next_s;
    logic [31:0]  sh_val_r, sh_step_s;
    logic [4:0]   sh_cnt_r, sh_rd_r;
    logic         sh_right_r, sh_arith_r;
    logic         ser_start_s, ser_done_s;

    assign ser_start_s = accept_s & ((op_s == OP_R) | (op_s == OP_IMM)) &
                         (f3_s[1:0] == 2'b01) & (alu_b_s[4:0] != 5'd0);
    assign ser_done_s  = (state_r == ST_SHIFT) & (sh_cnt_r == 5'd1) & ~hold_i;
    assign sh_step_s   = shift_fn(sh_val_r, 5'd1, sh_right_r, sh_arith_r);

    // Shift state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shift next-state: enter on a non-zero shift accept, leave on the last bit
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = ser_start_s ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next_s = ser_done_s ? ST_IDLE : ST_SHIFT;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Shift outputs: block new instructions while a shift is iterating
    always_comb begin
        if (state_r == ST_SHIFT) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Serial shift datapath: latch operand on start, one bit per non-held cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_val_r   <= 32'd0;
            sh_cnt_r   <= 5'd0;
            sh_rd_r    <= 5'd0;
            sh_right_r <= 1'b0;
            sh_arith_r <= 1'b0;
        end else if (!hold_i) begin
            if (ser_start_s) begin
                sh_val_r   <= a_s;
                sh_cnt_r   <= alu_b_s[4:0];
                sh_rd_r    <= opcode_rd_idx_i;
                sh_right_r <= f3_s[2];
                sh_arith_r <= opcode_opcode_i[30];
            end else if (state_r == ST_SHIFT) begin
                sh_val_r   <= sh_step_s;
                sh_cnt_r   <= sh_cnt_r - 5'd1;
            end
        end
    end

    // Stage 0 input: serial shift result takes the slot on its final step
    always_comb begin
        s0_valid_s = accept_s;
        s0_rd_s    = opcode_rd_idx_i;
        s0_val_s   = result_s;
        if (state_r == ST_SHIFT) begin
            s0_valid_s = (sh_cnt_r == 5'd1);
            s0_rd_s    = sh_rd_r;
            s0_val_s   = sh_step_s;
        end else if (ser_start_s) begin
            s0_valid_s = 1'b0;
        end else begin
            s0_valid_s = accept_s;
        end
    end
`else
    assign stall_s = 1'b0;

    // Stage 0 input: accepted instruction result, else a bubble
    always_comb begin
        s0_valid_s = accept_s;
        s0_rd_s    = opcode_rd_idx_i;
        s0_val_s   = result_s;
    end
`endif

    assign stall_o = stall_s;

    logic [RESULT_STAGES-1:0] stg_valid_r;
    logic [4:0]               stg_rd_r  [RESULT_STAGES];
    logic [31:0]              stg_val_r [RESULT_STAGES];

    // Result pipeline: all stages advance together unless held
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_valid_r <= {RESULT_STAGES{1'b0}};
            for (int i = 0; i < RESULT_STAGES; i++) begin
                stg_rd_r[i]  <= 5'd0;
                stg_val_r[i] <= 32'd0;
            end
        end else if (!hold_i) begin
            stg_valid_r[0] <= s0_valid_s;
            stg_rd_r[0]    <= s0_rd_s;
            stg_val_r[0]   <= s0_val_s;
            for (int i = 1; i < RESULT_STAGES; i++) begin
                stg_valid_r[i] <= stg_valid_r[i-1];
                stg_rd_r[i]    <= stg_rd_r[i-1];
                stg_val_r[i]   <= stg_val_r[i-1];
            end
        end
    end

    assign writeback_valid_o  = stg_valid_r[LAST] & (stg_rd_r[LAST] != 5'd0);
    assign writeback_rd_idx_o = stg_rd_r[LAST];
    assign writeback_value_o  = ext_complete_i ? ext_result_i : stg_val_r[LAST];

endmodule

// File: tb/tb_biriscv_exec_pipe.sv
// Directed self-checking bench for biriscv_exec_pipe (RESULT_STAGES=2).
module tb_biriscv_exec_pipe;
    localparam int RS = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        opcode_valid_i = 1'b0;
    logic [31:0] opcode_opcode_i = 32'd0;
    logic [31:0] opcode_pc_i = 32'd0;
    logic [4:0]  opcode_rd_idx_i = 5'd0;
    logic [4:0]  opcode_ra_idx_i = 5'd0;
    logic [31:0] opcode_ra_operand_i = 32'd0;
    logic [31:0] opcode_rb_operand_i = 32'd0;
    logic        hold_i = 1'b0;
    logic        ext_complete_i = 1'b0;
    logic [31:0] ext_result_i = 32'd0;
    logic        stall_o, writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;
    logic        branch_request_o, branch_is_taken_o, branch_is_not_taken_o;
    logic [31:0] branch_source_o, branch_pc_o, branch_d_pc_o;
    logic        branch_is_call_o, branch_is_ret_o, branch_is_jmp_o, branch_d_request_o;

    int checks = 0;
    int errors = 0;

    biriscv_exec_pipe #(.RESULT_STAGES(RS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
        .opcode_pc_i(opcode_pc_i), .opcode_rd_idx_i(opcode_rd_idx_i),
        .opcode_ra_idx_i(opcode_ra_idx_i), .opcode_ra_operand_i(opcode_ra_operand_i),
        .opcode_rb_operand_i(opcode_rb_operand_i), .hold_i(hold_i),
        .ext_complete_i(ext_complete_i), .ext_result_i(ext_result_i),
        .stall_o(stall_o), .writeback_valid_o(writeback_valid_o),
        .writeback_rd_idx_o(writeback_rd_idx_o), .writeback_value_o(writeback_value_o),
        .branch_request_o(branch_request_o), .branch_is_taken_o(branch_is_taken_o),
        .branch_is_not_taken_o(branch_is_not_taken_o), .branch_source_o(branch_source_o),
        .branch_pc_o(branch_pc_o), .branch_is_call_o(branch_is_call_o),
        .branch_is_ret_o(branch_is_ret_o), .branch_is_jmp_o(branch_is_jmp_o),
        .branch_d_request_o(branch_d_request_o), .branch_d_pc_o(branch_d_pc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [4:0] ra_idx, input logic [31:0] a, input logic [31:0] b);
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = instr;
        opcode_pc_i         = pc;
        opcode_rd_idx_i     = rd;
        opcode_ra_idx_i     = ra_idx;
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
    endtask

    // Issue one instruction and poll (bounded) for its writeback
    task automatic run_op(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] val, output logic got);
        for (int i = 0; i < 64 && stall_o; i++) tick();
        drive(instr, pc, rd, 5'd1, a, b);
        tick();
        opcode_valid_i = 1'b0;
        got = 1'b0;
        val = 32'd0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (writeback_valid_o) begin
                got = 1'b1;
                val = writeback_value_o;
            end else begin
                tick();
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++;
        if ({stall_o, writeback_valid_o, branch_request_o, branch_is_taken_o, branch_is_not_taken_o,
             branch_is_call_o, branch_is_ret_o, branch_is_jmp_o, branch_d_request_o} !== 9'd0) begin
            errors++;
            $display("FAIL reset_flags: stall=%b wbv=%b breq=%b", stall_o, writeback_valid_o, branch_request_o);
        end
        checks++;
        if ({branch_pc_o, branch_source_o, writeback_value_o} !== 96'd0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h src=%h wbval=%h, need 0", branch_pc_o, branch_source_o, writeback_value_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_addi_latency();
        logic [2:0] seen;
        drive(32'h0070_0293, 32'h0, 5'd5, 5'd0, 32'd0, 32'd0);
        seen[0] = writeback_valid_o;
        tick();
        opcode_valid_i = 1'b0;
        seen[1] = writeback_valid_o;
        tick();
        checks++;
        if (!(writeback_valid_o === 1'b1 && writeback_rd_idx_o === 5'd5 && writeback_value_o === 32'd7)) begin
            errors++;
            $display("FAIL addi_wb: v=%b rd=%0d val=%h, need 1/5/7", writeback_valid_o, writeback_rd_idx_o, writeback_value_o);
        end
        tick();
        seen[2] = writeback_valid_o;
        checks++;
        if (seen !== 3'b000) begin
            errors++;
            $display("FAIL addi_only_cycle2: valid in cycles 0,1,3 = %b, need 000", seen);
        end
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] ins [19];
        logic [31:0] av [19];
        logic [31:0] bv [19];
        logic [31:0] ex [19];
        logic [31:0] v;
        logic        g;
        ins[0]  = enc_r(7'h00, 3'b000, 5'd10);                av[0]  = 32'd5;        bv[0]  = 32'd3;  ex[0]  = 32'd8;
        ins[1]  = enc_r(7'h20, 3'b000, 5'd10);                av[1]  = 32'd3;        bv[1]  = 32'd5;  ex[1]  = 32'hFFFF_FFFE;
        ins[2]  = enc_r(7'h00, 3'b111, 5'd10);                av[2]  = 32'hF0F0;     bv[2]  = 32'hFF00; ex[2] = 32'hF000;
        ins[3]  = enc_r(7'h00, 3'b110, 5'd10);                av[3]  = 32'hF0F0;     bv[3]  = 32'hFF00; ex[3] = 32'hFFF0;
        ins[4]  = enc_r(7'h00, 3'b100, 5'd10);                av[4]  = 32'hF0F0;     bv[4]  = 32'hFF00; ex[4] = 32'h0FF0;
        ins[5]  = enc_r(7'h00, 3'b010, 5'd10);                av[5]  = 32'hFFFF_FFFF; bv[5] = 32'd1;  ex[5]  = 32'd1;
        ins[6]  = enc_r(7'h00, 3'b011, 5'd10);                av[6]  = 32'hFFFF_FFFF; bv[6] = 32'd1;  ex[6]  = 32'd0;
        ins[7]  = enc_r(7'h00, 3'b001, 5'd10);                av[7]  = 32'd1;        bv[7]  = 32'h21; ex[7]  = 32'd2;
        ins[8]  = enc_r(7'h00, 3'b101, 5'd10);                av[8]  = 32'h8000_0000; bv[8] = 32'd4;  ex[8]  = 32'h0800_0000;
        ins[9]  = enc_r(7'h20, 3'b101, 5'd10);                av[9]  = 32'h8000_0000; bv[9] = 32'd4;  ex[9]  = 32'hF800_0000;
        ins[10] = enc_i(12'hFFD, 5'd1, 3'b000, 5'd10, 7'h13); av[10] = 32'd10;       bv[10] = 32'd0;  ex[10] = 32'd7;
        ins[11] = enc_i(12'hFFF, 5'd1, 3'b100, 5'd10, 7'h13); av[11] = 32'h0F0F_0F0F; bv[11] = 32'd0; ex[11] = 32'hF0F0_F0F0;
        ins[12] = enc_i(12'h001, 5'd1, 3'b011, 5'd10, 7'h13); av[12] = 32'd0;        bv[12] = 32'd0;  ex[12] = 32'd1;
        ins[13] = enc_i(12'h404, 5'd1, 3'b101, 5'd10, 7'h13); av[13] = 32'h8000_0000; bv[13] = 32'd0; ex[13] = 32'hF800_0000;
        ins[14] = {20'h12345, 5'd10, 7'b0110111};             av[14] = 32'd0;        bv[14] = 32'd0;  ex[14] = 32'h1234_5000;
        ins[15] = {20'h00001, 5'd10, 7'b0010111};             av[15] = 32'd0;        bv[15] = 32'd0;  ex[15] = 32'h0000_1100;
        ins[16] = enc_j(32'd8, 5'd10);                        av[16] = 32'd0;        bv[16] = 32'd0;  ex[16] = 32'h0000_0104;
        ins[17] = 32'h0000_050B;                              av[17] = 32'd5;        bv[17] = 32'd5;  ex[17] = 32'd0;
        ins[18] = enc_i(12'h000, 5'd1, 3'b001, 5'd10, 7'h13); av[18] = 32'h55;       bv[18] = 32'd0;  ex[18] = 32'h55;
        for (int i = 0; i < 19; i++) begin
            run_op(ins[i], 32'h100, 5'd10, av[i], bv[i], v, g);
            checks++;
            if (g !== 1'b1 || v !== ex[i]) begin
                errors++;
                $display("FAIL alu_vec%0d: got_wb=%b value=%h, need 1/%h", i, g, v, ex[i]);
            end
        end
    endtask

    task automatic test_rd_zero();
        logic seen;
        seen = 1'b0;
        drive(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13), 32'h0, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        opcode_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | writeback_valid_o;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rd_zero: writeback_valid seen=%b, need 0", seen);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [10], pcs [10], av [10], bv [10], tgt [10];
        logic [4:0]  rai [10], rdi [10];
        logic [3:0]  fl [10]; // taken, call, ret, jmp
        ins[0] = enc_b(32'd16, 3'b000);         pcs[0] = 32'h100; av[0] = 32'd5;         bv[0] = 32'd5; rai[0] = 5'd1; rdi[0] = 5'd0; tgt[0] = 32'h110;  fl[0] = 4'b1000;
        ins[1] = enc_b(32'd16, 3'b001);         pcs[1] = 32'h100; av[1] = 32'd5;         bv[1] = 32'd5; rai[1] = 5'd1; rdi[1] = 5'd0; tgt[1] = 32'h104;  fl[1] = 4'b0000;
        ins[2] = enc_b(32'hFFFF_FFF8, 3'b100);  pcs[2] = 32'h200; av[2] = 32'hFFFF_FFFF; bv[2] = 32'd1; rai[2] = 5'd1; rdi[2] = 5'd0; tgt[2] = 32'h1F8;  fl[2] = 4'b1000;
        ins[3] = enc_b(32'hFFFF_FFF8, 3'b101);  pcs[3] = 32'h200; av[3] = 32'hFFFF_FFFF; bv[3] = 32'd1; rai[3] = 5'd1; rdi[3] = 5'd0; tgt[3] = 32'h204;  fl[3] = 4'b0000;
        ins[4] = enc_b(32'hFFFF_FFF8, 3'b110);  pcs[4] = 32'h200; av[4] = 32'hFFFF_FFFF; bv[4] = 32'd1; rai[4] = 5'd1; rdi[4] = 5'd0; tgt[4] = 32'h204;  fl[4] = 4'b0000;
        ins[5] = enc_b(32'hFFFF_FFF8, 3'b111);  pcs[5] = 32'h200; av[5] = 32'hFFFF_FFFF; bv[5] = 32'd1; rai[5] = 5'd1; rdi[5] = 5'd0; tgt[5] = 32'h1F8;  fl[5] = 4'b1000;
        ins[6] = enc_j(32'h40, 5'd1);           pcs[6] = 32'h300; av[6] = 32'd0;         bv[6] = 32'd0; rai[6] = 5'd0; rdi[6] = 5'd1; tgt[6] = 32'h340;  fl[6] = 4'b1100;
        ins[7] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67); pcs[7] = 32'h300; av[7] = 32'h1235; bv[7] = 32'd0; rai[7] = 5'd1; rdi[7] = 5'd0; tgt[7] = 32'h1234; fl[7] = 4'b1010;
        ins[8] = enc_j(32'h40, 5'd0);           pcs[8] = 32'h300; av[8] = 32'd0;         bv[8] = 32'd0; rai[8] = 5'd0; rdi[8] = 5'd0; tgt[8] = 32'h340;  fl[8] = 4'b1001;
        ins[9] = enc_i(12'd4, 5'd5, 3'b000, 5'd1, 7'h67); pcs[9] = 32'h300; av[9] = 32'h1000; bv[9] = 32'd0; rai[9] = 5'd5; rdi[9] = 5'd1; tgt[9] = 32'h1004; fl[9] = 4'b1100;
        for (int i = 0; i < 10; i++) begin
            drive(ins[i], pcs[i], rdi[i], rai[i], av[i], bv[i]);
            #1;
            checks++;
            if (branch_d_request_o !== fl[i][3] || (fl[i][3] && branch_d_pc_o !== tgt[i])) begin
                errors++;
                $display("FAIL br%0d_dreq: req=%b pc=%h, need %b/%h", i, branch_d_request_o, branch_d_pc_o, fl[i][3], tgt[i]);
            end
            tick();
            opcode_valid_i = 1'b0;
            checks++;
            if ({branch_request_o, branch_is_taken_o, branch_is_not_taken_o, branch_is_call_o, branch_is_ret_o, branch_is_jmp_o}
                    !== {1'b1, fl[i][3], ~fl[i][3], fl[i][2:0]} ||
                branch_pc_o !== tgt[i] || branch_source_o !== pcs[i]) begin
                errors++;
                $display("FAIL br%0d_flags: req/t/nt/call/ret/jmp=%b%b%b%b%b%b pc=%h src=%h, need 1%b%b%b pc=%h src=%h",
                         i, branch_request_o, branch_is_taken_o, branch_is_not_taken_o, branch_is_call_o,
                         branch_is_ret_o, branch_is_jmp_o, branch_pc_o, branch_source_o,
                         fl[i][3], ~fl[i][3], fl[i][2:0], tgt[i], pcs[i]);
            end
            tick();
            checks++;
            if (branch_request_o !== 1'b0 || branch_is_taken_o !== 1'b0 || branch_is_not_taken_o !== 1'b0) begin
                errors++;
                $display("FAIL br%0d_clear: req=%b t=%b nt=%b, need 0", i, branch_request_o, branch_is_taken_o, branch_is_not_taken_o);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_branch_hold();
        drive(enc_b(32'd16, 3'b000), 32'h100, 5'd0, 5'd1, 32'd9, 32'd9);
        tick();
        opcode_valid_i = 1'b0;
        hold_i = 1'b1;
        tick();
        tick();
        checks++;
        if (branch_request_o !== 1'b1 || branch_is_taken_o !== 1'b1 || branch_pc_o !== 32'h110) begin
            errors++;
            $display("FAIL br_hold: req=%b t=%b pc=%h, need 1/1/110", branch_request_o, branch_is_taken_o, branch_pc_o);
        end
        hold_i = 1'b0;
        tick();
        checks++;
        if (branch_request_o !== 1'b0) begin
            errors++;
            $display("FAIL br_hold_release: req=%b, need 0", branch_request_o);
        end
    endtask

    task automatic test_hold();
        drive(enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'h13), 32'h0, 5'd6, 5'd0, 32'd0, 32'd0);
        tick();
        drive(enc_i(12'd2, 5'd0, 3'b000, 5'd7, 7'h13), 32'h4, 5'd7, 5'd0, 32'd0, 32'd0);
        tick();
        drive(enc_i(12'd3, 5'd0, 3'b000, 5'd8, 7'h13), 32'h8, 5'd8, 5'd0, 32'd0, 32'd0);
        tick();
        drive(enc_i(12'd9, 5'd0, 3'b000, 5'd9, 7'h13), 32'hC, 5'd9, 5'd0, 32'd0, 32'd0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (writeback_valid_o !== 1'b1 || writeback_rd_idx_o !== 5'd7 || writeback_value_o !== 32'd2) begin
                errors++;
                $display("FAIL hold_frozen%0d: v=%b rd=%0d val=%h, need 1/7/2", i, writeback_valid_o, writeback_rd_idx_o, writeback_value_o);
            end
            tick();
        end
        hold_i = 1'b0;
        opcode_valid_i = 1'b0;
        checks++;
        if (writeback_valid_o !== 1'b1 || writeback_rd_idx_o !== 5'd7) begin
            errors++;
            $display("FAIL hold_last: v=%b rd=%0d, need 1/7", writeback_valid_o, writeback_rd_idx_o);
        end
        tick();
        checks++;
        if (writeback_valid_o !== 1'b1 || writeback_rd_idx_o !== 5'd8 || writeback_value_o !== 32'd3) begin
            errors++;
            $display("FAIL hold_resume: v=%b rd=%0d val=%h, need 1/8/3", writeback_valid_o, writeback_rd_idx_o, writeback_value_o);
        end
        tick();
        checks++;
        if (writeback_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_dup: v=%b rd=%0d, need 0", writeback_valid_o, writeback_rd_idx_o);
        end
        tick();
    endtask

    task automatic test_ext();
        drive(enc_r(7'h00, 3'b000, 5'd9), 32'h0, 5'd9, 5'd1, 32'd5, 32'd3);
        tick();
        opcode_valid_i = 1'b0;
        tick();
        ext_complete_i = 1'b1;
        ext_result_i   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (writeback_value_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ext_override: val=%h, need deadbeef", writeback_value_o);
        end
        ext_complete_i = 1'b0;
        #1;
        checks++;
        if (writeback_value_o !== 32'd8 || writeback_rd_idx_o !== 5'd9) begin
            errors++;
            $display("FAIL ext_release: val=%h rd=%0d, need 8/9", writeback_value_o, writeback_rd_idx_o);
        end
        tick();
        tick();
    endtask

    task automatic test_shift();
        int          cnt;
        logic [31:0] v;
        logic        g;
        cnt = 0;
        drive(enc_i(12'd4, 5'd1, 3'b001, 5'd3, 7'h13), 32'h0, 5'd3, 5'd1, 32'd1, 32'd0);
        tick();
        opcode_valid_i = 1'b0;
        for (int i = 0; i < 40 && stall_o; i++) begin
            cnt++;
            tick();
        end
        g = 1'b0;
        v = 32'd0;
        for (int i = 0; i < 10 && !g; i++) begin
            if (writeback_valid_o) begin
                g = 1'b1;
                v = writeback_value_o;
            end else begin
                tick();
            end
        end
        tick();
        tick();
        checks++;
`ifdef EXEC_SERIAL_SHIFT_EN
        if (cnt !== 4) begin
            errors++;
            $display("FAIL slli_stall: stall cycles=%0d, need 4", cnt);
        end
`else
        if (cnt !== 0) begin
            errors++;
            $display("FAIL slli_stall: stall cycles=%0d, need 0", cnt);
        end
`endif
        checks++;
        if (g !== 1'b1 || v !== 32'h10) begin
            errors++;
            $display("FAIL slli_value: got=%b val=%h, need 1/10", g, v);
        end
        run_op(enc_i(12'h41F, 5'd1, 3'b101, 5'd3, 7'h13), 32'h0, 5'd3, 32'h8000_0000, 32'd0, v, g);
        checks++;
        if (g !== 1'b1 || v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL srai31: got=%b val=%h, need 1/ffffffff", g, v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        g;
        drive(enc_i(12'd4, 5'd0, 3'b000, 5'd4, 7'h13), 32'h0, 5'd4, 5'd0, 32'd0, 32'd0);
        tick();
        drive(enc_i(12'd20, 5'd1, 3'b001, 5'd3, 7'h13), 32'h4, 5'd3, 5'd1, 32'd1, 32'd0);
        tick();
        opcode_valid_i = 1'b0;
        checks++;
        if (writeback_valid_o !== 1'b1 || writeback_rd_idx_o !== 5'd4) begin
            errors++;
            $display("FAIL rstmid_pre: v=%b rd=%0d, need 1/4", writeback_valid_o, writeback_rd_idx_o);
        end
`ifdef EXEC_SERIAL_SHIFT_EN
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stall_pre: stall=%b, need 1", stall_o);
        end
`endif
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || writeback_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_immediate: stall=%b wbv=%b, need 0/0", stall_o, writeback_valid_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        run_op(enc_i(12'd4, 5'd0, 3'b000, 5'd4, 7'h13), 32'h0, 5'd4, 32'd0, 32'd0, v, g);
        checks++;
        if (g !== 1'b1 || v !== 32'd4) begin
            errors++;
            $display("FAIL rstmid_after: got=%b val=%h, need 1/4", g, v);
        end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_alu();
        test_rd_zero();
        test_branch();
        test_branch_hold();
        test_hold();
        test_ext();
        test_shift();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
